serial_subtractor: RTL and testbench

//   Multi-cycle bit-serial two's-complement subtractor: diff = a - b, computed LSB-first with one full-adder cell
//   (b inverted, initial carry 1), one bit per clock. Area-cheap inverse of the ripple adder path; feeds the ALU

---
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
//
// Handshake: start is the request "valid" and ready is its "ready"; an
// operation transfers on a rising clock edge where start && ready are both 1,
// and a/b are captured on that edge only. done is a one-cycle pulse marking
// diff and the N/Z/C/V flags as freshly valid; the results then hold until
// the next done or reset. There is no back-pressure on done.
interface serial_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, done, diff, negative, zero, carry_out, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, done, diff, negative, zero, carry_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one
// full-adder cell per clock (b inverted, carry seeded with 1).
// Produces ARM-style N/Z/C/V flags; C=1 means no borrow.
module serial_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic [WIDTH-1:0] diff_q;
  logic             neg_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic             bit_a;
  logic             bit_nb;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Single full-adder cell on the current LSBs; b is inverted for subtraction.
  assign bit_a      = a_sr[0];
  assign bit_nb     = ~b_sr[0];
  assign sum_bit    = bit_a ^ bit_nb ^ carry_q;
  assign carry_next = (bit_a & bit_nb) | ((bit_a ^ bit_nb) & carry_q);
  assign res_next   = {sum_bit, res_sr[WIDTH-1:1]};
  assign last_bit   = (state_q == RUN) && (count_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result/flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      count_q <= '0;
      carry_q <= 1'b1;
      diff_q  <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_q <= 1'b1;
            count_q <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry_q <= carry_next;
          count_q <= count_q + CNT_W'(1);
          if (last_bit) begin
            diff_q <= res_next;
            neg_q  <= sum_bit;
            zero_q <= ~|res_next;
            cout_q <= carry_next;
            // carry_q here is still the carry into the MSB cell.
            ovf_q  <= carry_q ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=64 and WIDTH=8.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] st64;
  logic [1:0] st8;

  serial_subtractor_if #(.WIDTH(64)) if64 ();
  serial_subtractor_if #(.WIDTH(8))  if8 ();

  serial_subtractor #(.WIDTH(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64), .dbg_state(st64));
  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8),  .dbg_state(st8));

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference models: {diff, N, Z, C, V}
  function automatic logic [67:0] model64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic c;
    logic v;
    d = a - b;
    c = (a >= b);
    v = (a[63] != b[63]) && (d[63] != a[63]);
    return {d, d[63], (d == 64'd0), c, v};
  endfunction

  function automatic logic [11:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    logic c;
    logic v;
    d = a - b;
    c = (a >= b);
    v = (a[7] != b[7]) && (d[7] != a[7]);
    return {d, d[7], (d == 8'd0), c, v};
  endfunction

  // Scoreboard: push on accepted start, pop/compare on done
  logic [67:0] exp_q[$];
  int          acc_q[$];
  logic [11:0] exp8_q[$];
  int          acc8_q[$];
  int          done_cnt64 = 0;
  int          done_cnt8 = 0;
  logic        prev_done64 = 1'b0;
  logic        prev_done8 = 1'b0;

  always @(negedge clk) begin
    if (reset_n && if64.start && if64.ready) begin
      exp_q.push_back(model64(if64.a, if64.b));
      acc_q.push_back(cyc + 1);
    end
    if (prev_done64) check("done64_width", if64.done, 0);
    if (reset_n && if64.done) begin
      done_cnt64++;
      check("done64_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("result64", {if64.diff, if64.negative, if64.zero, if64.carry_out, if64.overflow},
              exp_q.pop_front());
        check("latency64", cyc - acc_q.pop_front(), 64);
      end
    end
    prev_done64 = if64.done;
  end

  always @(negedge clk) begin
    if (reset_n && if8.start && if8.ready) begin
      exp8_q.push_back(model8(if8.a, if8.b));
      acc8_q.push_back(cyc + 1);
    end
    if (prev_done8) check("done8_width", if8.done, 0);
    if (reset_n && if8.done) begin
      done_cnt8++;
      check("done8_expected", exp8_q.size() != 0, 1);
      if (exp8_q.size() != 0) begin
        check("result8", {if8.diff, if8.negative, if8.zero, if8.carry_out, if8.overflow},
              exp8_q.pop_front());
        check("latency8", cyc - acc8_q.pop_front(), 8);
      end
    end
    prev_done8 = if8.done;
  end

  // Driver tasks
  task automatic wait_done(input bit w8, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (w8 ? if8.done : if64.done) seen = 1;
      else if (n == 1) check({tag, "_ready_low"}, w8 ? if8.ready : if64.ready, 0);
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic do_op(input bit w8, input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    while (!(w8 ? if8.ready : if64.ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", w8 ? if8.ready : if64.ready, 1);
    @(posedge clk); #2;
    if (w8) begin
      if8.start = 1'b1; if8.a = a[7:0]; if8.b = b[7:0];
    end else begin
      if64.start = 1'b1; if64.a = a; if64.b = b;
    end
    @(posedge clk); #2;
    // Operands are free to change once accepted.
    if (w8) begin
      if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
    end else begin
      if64.start = 1'b0; if64.a = {$urandom, $urandom}; if64.b = {$urandom, $urandom};
    end
    wait_done(w8, w8 ? "op8" : "op64");
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] diff;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    int k;
    int n;
    int t[3];
    int gap;
    logic [63:0] ra;
    logic [63:0] rb;

    vecs[0] = '{64'd5, 64'd3, 64'd2, 4'b0010};
    vecs[1] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[4] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 4'b0110};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 4'b0010};
    vecs[6] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[7] = '{64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1001};

    if64.start = 1'b0; if64.a = '0; if64.b = '0;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready64", if64.ready, 1);
    check("rst_done64", if64.done, 0);
    check("rst_out64", {if64.diff, if64.negative, if64.zero, if64.carry_out, if64.overflow}, 0);
    check("rst_state64", st64, 0);
    check("rst_ready8", if8.ready, 1);
    check("rst_out8", {if8.diff, if8.negative, if8.zero, if8.carry_out, if8.overflow}, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      do_op(0, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_diff", i), if64.diff, vecs[i].diff);
      check($sformatf("vec%0d_nzcv", i),
            {if64.negative, if64.zero, if64.carry_out, if64.overflow}, vecs[i].nzcv);
    end

    // start pulsed mid-RUN is ignored
    repeat (2) @(negedge clk);
    base = done_cnt64;
    @(posedge clk); #2;
    if64.start = 1'b1; if64.a = 64'd1000; if64.b = 64'd7;
    @(posedge clk); #2;
    if64.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    if64.start = 1'b1; if64.a = 64'd50; if64.b = 64'd60;
    @(negedge clk);
    check("midrun_ready", if64.ready, 0);
    @(posedge clk); #2;
    if64.start = 1'b0;
    wait_done(0, "midrun");
    check("midrun_diff", if64.diff, 64'd993);
    repeat (100) @(negedge clk);
    check("midrun_one_done", done_cnt64 - base, 1);
    check("midrun_q_empty", exp_q.size(), 0);

    // start held high: back-to-back operations
    @(posedge clk); #2;
    if64.start = 1'b1; if64.a = 64'h0000_0001_0000_0000; if64.b = 64'h1;
    k = 0;
    n = 0;
    while (k < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (if64.done) begin
        t[k] = cyc;
        k++;
      end
    end
    check("b2b_count", k, 3);
    if (k == 3) begin
      for (int j = 1; j < 3; j++) begin
        gap = t[j] - t[j-1];
        check($sformatf("b2b_gap%0d_in_65_66(gap=%0d)", j, gap), (gap >= 65 && gap <= 66), 1);
      end
    end
    @(posedge clk); #2;
    if64.start = 1'b0;
    n = 0;
    while (!(if64.ready && exp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", exp_q.size(), 0);

    // Asynchronous reset at RUN cycle 20 aborts the operation
    @(posedge clk); #2;
    if64.start = 1'b1; if64.a = 64'h55; if64.b = 64'h22;
    @(posedge clk); #2;
    if64.start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_ready", if64.ready, 1);
    check("abort_done", if64.done, 0);
    check("abort_out", {if64.diff, if64.negative, if64.zero, if64.carry_out, if64.overflow}, 0);
    check("abort_state", st64, 0);
    exp_q.delete();
    acc_q.delete();
    base = done_cnt64;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", done_cnt64 - base, 0);
    do_op(0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_FFFF);
    check("post_abort_diff", if64.diff, 64'h0123_4567_89AA_CDF0);

    // Random operands, both widths
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = (i == 3) ? ra : {$urandom, $urandom};
      do_op(0, ra, rb);
    end
    for (int i = 0; i < 24; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = (i % 8 == 5) ? ra : 64'($urandom_range(0, 255));
      do_op(1, ra, rb);
    end
    repeat (5) @(negedge clk);
    check("final_q64_empty", exp_q.size(), 0);
    check("final_q8_empty", exp8_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
